l2_port_arbiter: RTL and testbench
==================================

Name: l2_port_arbiter

Overview:
- Shares the single-ported L2 SRAM between two TCDM-style bus masters.
- Master 0 is the JTAG debug bus master, which the PULP TAP drives for write32/read32 accesses. Master 1 is the SoC-side master (core/DMA).
- Arbitration is round-robin with a single-cycle grant and a fixed one-cycle response. Out-of-range and misaligned accesses are answered with an error response and never reach the SRAM.

Parameters:
- L2_BASE, 32'h0000_0000, byte base address of the L2 window.
- MEM_WORDS, 4096, SRAM depth in 32-bit words; must be a power of two.
- MEM_AW, $clog2(MEM_WORDS), SRAM word-address width (derived).
- ERR_RDATA, 32'hBADACCE5, rdata value returned on error responses.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  asynchronous active-high reset.
- m0_req_i  in  1  master 0 (JTAG) request.
- m0_addr_i  in  32  master 0 byte address.
- m0_we_i  in  1  master 0 write enable (1 = write).
- m0_be_i  in  4  master 0 byte enables.
- m0_wdata_i  in  32  master 0 write data.
- m0_gnt_o  out  1  master 0 grant (combinational).
- m0_rvalid_o  out  1  master 0 response valid.
- m0_rdata_o  out  32  master 0 read data.
- m0_err_o  out  1  master 0 error flag, qualified by m0_rvalid_o.
- m1_req_i, m1_addr_i, m1_we_i, m1_be_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o: identical to master 0, for master 1.
- mem_req_o  out  1  SRAM chip enable.
- mem_addr_o  out  MEM_AW  SRAM word address.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  4  SRAM byte enables.
- mem_wdata_o  out  32  SRAM write data.
- mem_rdata_i  in  32  SRAM read data, valid one cycle after a read with mem_req_o=1.
- conflict_cnt_o  out  16  saturating count of cycles in which both masters requested.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - Registered state cleared: rr_ptr=0, resp_valid=0, resp_owner=0, resp_err=0, resp_we=0, conflict_cnt=0.
  - While rst_i=1, gnt, mem_req_o and rvalid are forced to 0.
  - All rdata outputs read 0 during reset.
- Arbitration (combinational, same cycle):
  - Only one requester: that master is granted.
  - Both requesting: the master selected by rr_ptr wins and the loser's gnt stays 0.
  - A master must hold req and its payload stable until granted.
- Round-robin pointer update: after any grant to master k, rr_ptr <= ~k on the next edge. Consequence: master 0 wins the first conflict after reset, and masters alternate under sustained contention.
- Address decode, per granted request:
  - off = addr - L2_BASE (32-bit unsigned wrap).
  - Hit when off < MEM_WORDS*4 and addr[1:0]==2'b00.
  - Hit: mem_req_o=1, mem_addr_o=off[MEM_AW+1:2], with we/be/wdata forwarded unchanged.
  - Miss: the request is still granted, but mem_req_o=0 and no SRAM access occurs.
  - With no grant, mem_req_o=0 and all other mem_* outputs are 0.
- Response, fixed latency 1:
  - On a grant edge, the owner, the error flag (=miss) and we are captured into the response register.
  - Next cycle, owner's rvalid_o=1 for exactly one cycle; the other master's rvalid_o=0.
  - rdata: mem_rdata_i for a read hit, 0 for a write hit, ERR_RDATA on error.
  - err_o=1 only on a miss.
- Back-to-back operation: a new grant may occur in the same cycle as the previous response, giving one transaction per cycle of throughput.
- conflict_cnt: increments on every cycle with m0_req_i & m1_req_i and rst_i=0; saturates at 16'hFFFF.
- Reset mid-operation: an in-flight response is discarded (no rvalid after rst_i deasserts). An SRAM write already issued on the edge is not rolled back.

Test Plan:
- Single-master R/W: m0 writes 32'hABBAABBA to 32'h0000_0000 with be=4'hF, then reads the same address. Required: gnt in the request cycle, mem_addr_o=0, rvalid exactly 1 cycle later, read returns rdata=32'hABBAABBA, err=0.
- Contention: both masters request reads continuously for 4 cycles from reset. Required: grants go m0, m1, m0, m1; each rvalid goes only to its owner, one cycle after its grant; conflict_cnt_o=4.
- Out of range: m1 reads 32'h0000_4000 (MEM_WORDS=4096). Required: gnt=1, mem_req_o=0, then next cycle m1_rvalid_o=1, m1_err_o=1, m1_rdata_o=32'hBADACCE5.
- Misaligned and byte enables:
  - m0 writes 32'h0000_0002 → err response, no SRAM write.
  - m0 writes 32'h11223344 with be=4'b0011 to 32'h0000_0010 over the previous content 32'hFFFFFFFF, then reads it back. Required: mem_addr_o=4, be forwarded unchanged, readback 32'hFFFF3344.
- Reset mid-operation: assert rst_i in the cycle after a m0 read grant. Required: m0_rvalid_o stays 0 through and after reset, and rr_ptr=0 afterwards, so m0 wins the next conflict.
- Counter saturation: force both requests for 65540 cycles. Required: conflict_cnt_o holds 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
// Shares one single-ported L2 SRAM between two TCDM-style masters:
// master 0 (JTAG debug) and master 1 (SoC core/DMA). Round-robin arbitration
// with a same-cycle grant and a fixed one-cycle response. Requests outside
// the L2 window or not word aligned get an error response and never reach
// the SRAM.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   mN_req_i/addr_i/we_i/be_i/wdata_i   master N request payload
//   mN_gnt_o                     master N grant (combinational)
//   mN_rvalid_o/rdata_o/err_o    master N response, one cycle after grant
//   mem_req_o/addr_o/we_o/be_o/wdata_o  SRAM port
//   mem_rdata_i                  SRAM read data, one cycle after a read
//   conflict_cnt_o               saturating count of both-request cycles
module l2_port_arbiter #(
  parameter logic [31:0] L2_BASE   = 32'h0000_0000,
  parameter int          MEM_WORDS = 4096,
  parameter int          MEM_AW    = $clog2(MEM_WORDS),
  parameter logic [31:0] ERR_RDATA = 32'hBADACCE5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic [31:0]       m0_addr_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_be_i,
  input  logic [31:0]       m0_wdata_i,
  output logic              m0_gnt_o,
  output logic              m0_rvalid_o,
  output logic [31:0]       m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic [31:0]       m1_addr_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_be_i,
  input  logic [31:0]       m1_wdata_i,
  output logic              m1_gnt_o,
  output logic              m1_rvalid_o,
  output logic [31:0]       m1_rdata_o,
  output logic              m1_err_o,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [15:0]       conflict_cnt_o
);

  // Window size in bytes, kept 33 bits wide so a full 4 GiB window cannot wrap.
  localparam logic [32:0] WIN_BYTES = 33'(MEM_WORDS) << 2;

  // rr_ptr: 0 -> master 0 wins the next conflict, 1 -> master 1 wins.
  logic        rr_ptr_q,     rr_ptr_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_owner_q, resp_owner_d;
  logic        resp_err_q,   resp_err_d;
  logic        resp_we_q,    resp_we_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  logic        gnt0, gnt1, any_gnt, hit;
  logic [31:0] sel_addr, sel_wdata, off;
  logic        sel_we;
  logic [3:0]  sel_be;

  always_comb begin
    gnt0 = ~rst_i & m0_req_i & (~m1_req_i | ~rr_ptr_q);
    gnt1 = ~rst_i & m1_req_i & (~m0_req_i |  rr_ptr_q);
    any_gnt = gnt0 | gnt1;

    sel_addr  = gnt1 ? m1_addr_i  : m0_addr_i;
    sel_we    = gnt1 ? m1_we_i    : m0_we_i;
    sel_be    = gnt1 ? m1_be_i    : m0_be_i;
    sel_wdata = gnt1 ? m1_wdata_i : m0_wdata_i;

    off = sel_addr - L2_BASE;
    hit = ({1'b0, off} < WIN_BYTES) && (sel_addr[1:0] == 2'b00);

    // SRAM side is driven only for a granted in-range access; otherwise idle zeros.
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (any_gnt && hit) begin
      mem_req_o   = 1'b1;
      mem_addr_o  = off[MEM_AW+1:2];
      mem_we_o    = sel_we;
      mem_be_o    = sel_be;
      mem_wdata_o = sel_wdata;
    end

    rr_ptr_d = rr_ptr_q;
    if (gnt0)      rr_ptr_d = 1'b1;
    else if (gnt1) rr_ptr_d = 1'b0;

    resp_valid_d = any_gnt;
    resp_owner_d = gnt1;
    resp_err_d   = any_gnt & ~hit;
    resp_we_d    = any_gnt & sel_we;

    conflict_cnt_d = conflict_cnt_q;
    if (m0_req_i && m1_req_i && conflict_cnt_q != 16'hFFFF)
      conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q       <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_owner_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_we_q      <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      resp_valid_q   <= resp_valid_d;
      resp_owner_q   <= resp_owner_d;
      resp_err_q     <= resp_err_d;
      resp_we_q      <= resp_we_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  logic [31:0] resp_rdata;

  always_comb begin
    m0_gnt_o    = gnt0;
    m1_gnt_o    = gnt1;
    m0_rvalid_o = ~rst_i & resp_valid_q & ~resp_owner_q;
    m1_rvalid_o = ~rst_i & resp_valid_q &  resp_owner_q;

    if (resp_err_q)     resp_rdata = ERR_RDATA;
    else if (resp_we_q) resp_rdata = '0;
    else                resp_rdata = mem_rdata_i;

    // Non-owner (and everyone during reset) sees zeros.
    m0_rdata_o = m0_rvalid_o ? resp_rdata : '0;
    m1_rdata_o = m1_rvalid_o ? resp_rdata : '0;
    m0_err_o   = m0_rvalid_o & resp_err_q;
    m1_err_o   = m1_rvalid_o & resp_err_q;

    conflict_cnt_o = conflict_cnt_q;
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
module tb_l2_port_arbiter;

  localparam int          MEM_WORDS = 4096;
  localparam int          MEM_AW    = 12;
  localparam logic [31:0] ERR_RD    = 32'hBADACCE5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              m0_req, m1_req, m0_we, m1_we;
  logic [31:0]       m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]        m0_be, m1_be;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0]       m0_rdata, m1_rdata;
  logic              mem_req, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [15:0]       conflict_cnt;

  l2_port_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .conflict_cnt_o(conflict_cnt)
  );

  // Environment SRAM, driven only by the DUT's mem_* port.
  logic [31:0] sram [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  // Bench reference model state.
  typedef struct { bit owner; bit err; logic [31:0] rdata; } rsp_t;
  rsp_t        sb[$];
  logic [31:0] ref_mem [MEM_WORDS];
  bit          rr_m;
  int          cnt_m;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int m, input bit req, input logic [31:0] addr,
                     input bit we, input logic [3:0] be, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = req; m0_addr = addr; m0_we = we; m0_be = be; m0_wdata = wd;
    end else begin
      m1_req = req; m1_addr = addr; m1_we = we; m1_be = be; m1_wdata = wd;
    end
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
  endtask

  // One clock: at the falling edge check last cycle's response and this
  // cycle's grant/SRAM drive against the model, then advance past the edge.
  task automatic step();
    bit g0, g1, we, hit;
    logic [31:0] addr, wd, off;
    logic [3:0] be;
    rsp_t r;
    @(negedge clk);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      chk("rvalid_m0", {31'b0, m0_rvalid}, {31'b0, ~r.owner});
      chk("rvalid_m1", {31'b0, m1_rvalid}, {31'b0,  r.owner});
      chk("rdata", r.owner ? m1_rdata : m0_rdata, r.rdata);
      chk("err",   {31'b0, r.owner ? m1_err : m0_err}, {31'b0, r.err});
    end else begin
      chk("no_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    end
    g0 = m0_req && (!m1_req || !rr_m);
    g1 = m1_req && (!m0_req ||  rr_m);
    chk("gnt", {30'b0, m1_gnt, m0_gnt}, {30'b0, g1, g0});
    if (g0 || g1) begin
      addr = g1 ? m1_addr : m0_addr;
      we   = g1 ? m1_we : m0_we;
      be   = g1 ? m1_be : m0_be;
      wd   = g1 ? m1_wdata : m0_wdata;
      off  = addr;
      hit  = (off < MEM_WORDS * 4) && (addr[1:0] == 2'b00);
      chk("mem_req", {31'b0, mem_req}, {31'b0, hit});
      if (hit) begin
        chk("mem_addr",  {20'b0, mem_addr}, {20'b0, off[13:2]});
        chk("mem_we",    {31'b0, mem_we}, {31'b0, we});
        chk("mem_be",    {28'b0, mem_be}, {28'b0, be});
        chk("mem_wdata", mem_wdata, wd);
      end
      r.owner = g1;
      r.err   = !hit;
      r.rdata = !hit ? ERR_RD : (we ? 32'd0 : ref_mem[off[13:2]]);
      sb.push_back(r);
      if (hit && we)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[off[13:2]][8*b +: 8] = wd[8*b +: 8];
      rr_m = g0;
    end else begin
      chk("mem_req_idle", {31'b0, mem_req}, 32'd0);
    end
    if (m0_req && m1_req && cnt_m != 16'hFFFF) cnt_m++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    sb.delete();
    rr_m  = 1'b0;
    cnt_m = 0;
    chk("rst_gnt",    {30'b0, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_memreq", {31'b0, mem_req}, 32'd0);
    chk("rst_rvalid", {30'b0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_rdata0", m0_rdata, 32'd0);
    chk("rst_rdata1", m1_rdata, 32'd0);
    chk("rst_cnt",    {16'b0, conflict_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      sram[i]    = 32'h5A00_0000 ^ (i * 32'h0001_0203);
      ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0203);
    end
    mem_rdata = 32'd0;

    // Reset with both masters requesting: nothing may leak out.
    drv(0, 1, 32'h0, 0, 4'hF, 0);
    drv(1, 1, 32'h4, 0, 4'hF, 0);
    apply_reset();

    // Contention from reset: m0, m1, m0, m1.
    drv(0, 1, 32'h0000_0100, 0, 4'hF, 0);
    drv(1, 1, 32'h0000_0200, 0, 4'hF, 0);
    repeat (4) step();
    idle();
    chk("conflict_cnt4", {16'b0, conflict_cnt}, 32'd4);
    step();

    // Single-master write then read.
    drv(0, 1, 32'h0000_0000, 1, 4'hF, 32'hABBAABBA);
    step();
    drv(0, 1, 32'h0000_0000, 0, 4'hF, 0);
    step();
    idle();
    step();

    // Out-of-range read from m1.
    drv(1, 1, 32'h0000_4000, 0, 4'hF, 0);
    step();
    idle();
    step();

    // Misaligned write from m0: error, SRAM untouched.
    drv(0, 1, 32'h0000_0002, 1, 4'hF, 32'hDEADBEEF);
    step();
    // Partial-byte write over an all-ones word, then readback.
    drv(0, 1, 32'h0000_0010, 1, 4'hF, 32'hFFFFFFFF);
    step();
    drv(0, 1, 32'h0000_0010, 1, 4'b0011, 32'h11223344);
    step();
    drv(0, 1, 32'h0000_0010, 0, 4'hF, 0);
    step();
    idle();
    step();
    chk("sram_partial", sram[4], 32'hFFFF3344);
    chk("sram_misalign", sram[0], 32'hABBAABBA);

    // Back-to-back throughput with m1 alone; rr_ptr left pointing at m0.
    drv(1, 1, 32'h0000_0010, 0, 4'hF, 0);
    repeat (3) step();
    idle();
    step();

    // Drive rr_ptr to 1 (m0 grant), then reset while its response is pending.
    drv(0, 1, 32'h0000_0010, 0, 4'hF, 0);
    step();
    idle();
    apply_reset();
    step();
    step();
    // Pointer must be back at 0: m0 wins this conflict.
    drv(0, 1, 32'h0000_0000, 0, 4'hF, 0);
    drv(1, 1, 32'h0000_0004, 0, 4'hF, 0);
    step();
    chk("post_rst_rr", {31'b0, rr_m}, 32'd1);

    // Counter saturation under sustained contention.
    repeat (65540) step();
    chk("cnt_sat", {16'b0, conflict_cnt}, 32'h0000_FFFF);
    step();
    chk("cnt_hold", {16'b0, conflict_cnt}, 32'h0000_FFFF);
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
